// File: rtl/instr_ingress_fifo_if.sv
// Instruction ingress bus: HPS PIO side (strobe, data words, full status)
// and GPU decoder side (pop request, head data, valid, occupancy).
//   master : drives wrreg_in, data_a_in, data_b_in, rd_en (HPS + decoder)
//   slave  : drives wrfull_out, rd_data, rd_valid, usedw (the FIFO)
// Optional macro INGRESS_OVERFLOW_FLAG_EN adds overflow_out / overflow_clr.
interface instr_ingress_fifo_if #(
    parameter int unsigned ADDR_W = 4
);
    logic                wrreg_in;
    logic [31:0]         data_a_in;
    logic [31:0]         data_b_in;
    logic                wrfull_out;
    logic                rd_en;
    logic [63:0]         rd_data;
    logic                rd_valid;
    logic [ADDR_W:0]     usedw;
`ifdef INGRESS_OVERFLOW_FLAG_EN
    logic                overflow_out;
    logic                overflow_clr;
`endif

    modport master (
        output wrreg_in, data_a_in, data_b_in, rd_en,
`ifdef INGRESS_OVERFLOW_FLAG_EN
        output overflow_clr,
        input  overflow_out,
`endif
        input  wrfull_out, rd_data, rd_valid, usedw
    );

    modport slave (
        input  wrreg_in, data_a_in, data_b_in, rd_en,
`ifdef INGRESS_OVERFLOW_FLAG_EN
        input  overflow_clr,
        output overflow_out,
`endif
        output wrfull_out, rd_data, rd_valid, usedw
    );
endinterface

// File: rtl/instr_ingress_fifo.sv
// Instruction ingress FIFO: converts each rising edge of the HPS wrreg PIO
// into one 64-bit push {data_a, data_b} and buffers it in a first-word
// fall-through FIFO drained by the GPU instruction decoder.
// Ports:
//   clock, reset : system clock, asynchronous active-high reset
//   bus (slave)  : wrreg_in/data_a_in/data_b_in in, wrfull_out out,
//                  rd_en in, rd_data/rd_valid/usedw out
// Optional macro INGRESS_OVERFLOW_FLAG_EN: sticky overflow_out flag,
// cleared by overflow_clr.
module instr_ingress_fifo #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic                clock,
    input  logic                reset,
    instr_ingress_fifo_if.slave bus
);
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned DATA_W = 64;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic                wrreg_q, wrreg_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                push_req;
    logic                pop;
    logic                push_ok;
    logic                is_full;
    logic                is_empty;

    assign is_full  = (count_q == FULL_CNT);
    assign is_empty = (count_q == '0);

    // Next-state: edge detect, acceptance, pointer and count update
    always_comb begin
        wrreg_d  = bus.wrreg_in;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        push_req = bus.wrreg_in & ~wrreg_q;
        pop      = bus.rd_en & ~is_empty;
        // A push into a full FIFO is still accepted when the head leaves this cycle
        push_ok  = push_req & (~is_full | pop);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end

        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; wrreg_q resets high so a strobe held through reset is not a rise
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrreg_q  <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wrreg_q  <= wrreg_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, intentionally not cleared by reset
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {bus.data_a_in, bus.data_b_in};
        end
    end

    assign bus.rd_data    = mem_q[rd_ptr_q];
    assign bus.rd_valid   = ~is_empty;
    assign bus.wrfull_out = is_full;
    assign bus.usedw      = count_q;

`ifdef INGRESS_OVERFLOW_FLAG_EN
    logic overflow_q, overflow_d;

    // Sticky drop flag; a new drop wins over a same-cycle clear
    always_comb begin
        overflow_d = overflow_q & ~bus.overflow_clr;
        if (push_req & ~push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow_out = overflow_q;
`endif

endmodule

// File: tb/tb_instr_ingress_fifo.sv
// Scoreboard bench for instr_ingress_fifo: stimulus pushes expected entries
// into a queue, a negedge monitor pops and compares on every valid read.
module tb_instr_ingress_fifo;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 16;

    logic clock;
    logic reset;

    instr_ingress_fifo_if #(.ADDR_W(ADDR_W)) bus ();

    instr_ingress_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp;
    int n_fail;
    logic [63:0] exp_q [$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each cycle with a valid pop the head must match the scoreboard front
    always @(negedge clock) begin
        if (!reset && bus.rd_en && bus.rd_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL pop_unexpected: got %h expected no entry at %0t", bus.rd_data, $time);
            end else begin
                check("pop_data", bus.rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input bit with_pop, input bit accept);
        bus.data_a_in = a;
        bus.data_b_in = b;
        bus.wrreg_in  = 1'b1;
        if (with_pop) bus.rd_en = 1'b1;
        if (accept) exp_q.push_back({a, b});
        cyc(1);
        bus.wrreg_in = 1'b0;
        bus.rd_en    = 1'b0;
        cyc(1);
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        cyc(n);
        bus.rd_en = 1'b0;
    endtask

    // Drain until empty, bounded
    task automatic drain();
        int guard;
        guard = 0;
        bus.rd_en = 1'b1;
        while (bus.rd_valid && guard < 40) begin
            cyc(1);
            guard++;
        end
        bus.rd_en = 1'b0;
        check("drain_empty", 64'(bus.rd_valid), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b1;
        bus.wrreg_in  = 1'b0;
        bus.data_a_in = '0;
        bus.data_b_in = '0;
        bus.rd_en     = 1'b0;
`ifdef INGRESS_OVERFLOW_FLAG_EN
        bus.overflow_clr = 1'b0;
`endif
        cyc(3);
        check("rst_usedw",  64'(bus.usedw),      64'd0);
        check("rst_valid",  64'(bus.rd_valid),   64'd0);
        check("rst_full",   64'(bus.wrfull_out), 64'd0);
        reset = 1'b0;
        cyc(2);

        // Single push with strobe held for 5 cycles
        bus.data_a_in = 32'hDEADBEEF;
        bus.data_b_in = 32'h00000001;
        bus.wrreg_in  = 1'b1;
        exp_q.push_back(64'hDEADBEEF00000001);
        cyc(1);
        check("single_usedw", 64'(bus.usedw),    64'd1);
        check("single_valid", 64'(bus.rd_valid), 64'd1);
        check("single_data",  bus.rd_data,       64'hDEADBEEF00000001);
        cyc(4);
        check("held_usedw",   64'(bus.usedw),    64'd1);
        bus.wrreg_in = 1'b0;
        cyc(1);
        pop_n(1);
        check("single_pop_usedw", 64'(bus.usedw), 64'd0);

        // Fill to 16, then a dropped 17th push
        for (int i = 0; i < 16; i++) push(32'hF0000000 | 32'(i), 32'(i), 1'b0, 1'b1);
        check("fill_full",  64'(bus.wrfull_out), 64'd1);
        check("fill_usedw", 64'(bus.usedw),      64'd16);
        push(32'hF0000063, 32'd99, 1'b0, 1'b0);
        check("drop_usedw", 64'(bus.usedw),      64'd16);
`ifdef INGRESS_OVERFLOW_FLAG_EN
        check("ovf_set", 64'(bus.overflow_out), 64'd1);
`endif
        drain();
        check("drain_usedw", 64'(bus.usedw), 64'd0);
`ifdef INGRESS_OVERFLOW_FLAG_EN
        check("ovf_sticky", 64'(bus.overflow_out), 64'd1);
        bus.overflow_clr = 1'b1;
        cyc(1);
        bus.overflow_clr = 1'b0;
        check("ovf_clr", 64'(bus.overflow_out), 64'd0);
`endif

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(32'hE0000000 | 32'(i), 32'(i), 1'b0, 1'b1);
        push(32'hE00000AA, 32'h000000AA, 1'b1, 1'b1);
        check("fullpp_usedw", 64'(bus.usedw),      64'd16);
        check("fullpp_full",  64'(bus.wrfull_out), 64'd1);
        check("fullpp_head",  bus.rd_data,         64'hE0000001_00000001);
        drain();

        // Wrap-around
        for (int i = 0; i < 10; i++) push(32'hA0000000, 32'(i), 1'b0, 1'b1);
        pop_n(10);
        for (int i = 0; i < 10; i++) push(32'hB0000000, 32'(i), 1'b0, 1'b1);
        check("wrap_usedw10", 64'(bus.usedw), 64'd10);
        pop_n(10);
        check("wrap_usedw", 64'(bus.usedw),    64'd0);
        check("wrap_valid", 64'(bus.rd_valid), 64'd0);

        // Reset mid-operation with strobe held high
        for (int i = 0; i < 4; i++) push(32'hC0000000, 32'(i), 1'b0, 1'b1);
        bus.data_a_in = 32'hC0000000;
        bus.data_b_in = 32'd4;
        bus.wrreg_in  = 1'b1;
        cyc(1);
        check("pre_rst_usedw", 64'(bus.usedw), 64'd5);
        reset = 1'b1;
        exp_q.delete();
        cyc(2);
        reset = 1'b0;
        cyc(1);
        check("post_rst_usedw", 64'(bus.usedw), 64'd0);
        cyc(3);
        check("post_rst_held", 64'(bus.usedw), 64'd0);
        bus.wrreg_in  = 1'b0;
        cyc(1);
        bus.data_b_in = 32'd77;
        bus.wrreg_in  = 1'b1;
        exp_q.push_back({32'hC0000000, 32'd77});
        cyc(1);
        check("rerise_usedw", 64'(bus.usedw), 64'd1);
        bus.wrreg_in = 1'b0;
        cyc(1);
        pop_n(1);

        // Pop while empty, then a normal push
        pop_n(3);
        check("empty_pop_usedw", 64'(bus.usedw),    64'd0);
        check("empty_pop_valid", 64'(bus.rd_valid), 64'd0);
        push(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b1);
        check("after_empty_data", bus.rd_data, 64'h12345678_9ABCDEF0);
        pop_n(1);

        cyc(2);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
